sik_fetch: RTL and testbench

- Dual-thread instruction fetch stage for the pipelined SIK stack processor; sits directly upstream of decode.
- Alternates fetch between two hardware threads, each with its own PC, from the shared word-addressed instruction memory.
- Folds PRE prefix words into the next instruction of the same thread.
- Presents one registered instruction per cycle to decode over a valid/ready handshake.
- Handles redirects (jump/call/ret) and per-thread halt.

---
 rtl/sik_fetch.sv | 125 ++++++++++++
 tb/tb_sik_fetch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sik_fetch.sv
// Dual-thread SIK instruction fetch: alternates the two thread PCs, folds PRE
// prefix words into the following instruction and hands decode one registered word.
module sik_fetch #(
    parameter logic [15:0] T0_START = 16'h0000,
    parameter logic [15:0] T1_START = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_inst,
    output logic        out_tid,
    output logic [15:0] out_pc,
    output logic [3:0]  out_pre,
    output logic        out_pre_valid,
    input  logic        redirect_valid,
    input  logic        redirect_tid,
    input  logic [15:0] redirect_pc,
    input  logic [1:0]  halt_req,
    output logic        halted
);
    localparam int unsigned AW     = 16;
    localparam int unsigned PW     = 4;
    localparam logic [3:0]  PRE_OP = 4'hF;

    logic [1:0][AW-1:0] pc_q, pc_d;
    logic [1:0][PW-1:0] pre_val_q, pre_val_d;
    logic [1:0]         pre_pend_q, pre_pend_d;
    logic [1:0]         thread_halt_q, thread_halt_d;
    logic               sel_q, sel_d;
    logic               valid_d, tid_d, pre_valid_d, halted_d;
    logic [AW-1:0]      inst_d, opc_d;
    logic [PW-1:0]      pre_d;
    logic               adv, live, cand, kill, is_pre;

    // Candidate thread: the selected one unless it is halted.
    always_comb begin
        adv    = !out_valid || out_ready;
        live   = !(&thread_halt_q);
        cand   = thread_halt_q[sel_q] ? ~sel_q : sel_q;
        kill   = halt_req[cand] || (redirect_valid && (redirect_tid == cand));
        is_pre = (imem_data[AW-1 -: PW] == PRE_OP);
    end

    assign imem_addr = pc_q[cand];

    always_comb begin
        pc_d          = pc_q;
        sel_d         = sel_q;
        pre_pend_d    = pre_pend_q;
        pre_val_d     = pre_val_q;
        thread_halt_d = thread_halt_q | halt_req;
        valid_d       = out_valid;
        inst_d        = out_inst;
        tid_d         = out_tid;
        opc_d         = out_pc;
        pre_d         = out_pre;
        pre_valid_d   = out_pre_valid;
        halted_d      = halted || ((&thread_halt_q) && !out_valid);

        if (adv) begin
            valid_d = 1'b0;
            if (live) begin
                sel_d = ~sel_q;
                // A fetch of a thread being redirected or halted this cycle is dropped.
                if (!kill) begin
                    pc_d[cand] = pc_q[cand] + AW'(1);
                    if (is_pre) begin
                        pre_pend_d[cand] = 1'b1;
                        pre_val_d[cand]  = imem_data[PW-1:0];
                    end else begin
                        valid_d          = 1'b1;
                        inst_d           = imem_data;
                        tid_d            = cand;
                        opc_d            = pc_q[cand];
                        pre_d            = pre_val_q[cand];
                        pre_valid_d      = pre_pend_q[cand];
                        pre_pend_d[cand] = 1'b0;
                        pre_val_d[cand]  = '0;
                    end
                end
            end
        end else if (redirect_valid && (redirect_tid == out_tid)) begin
            valid_d = 1'b0;
        end

        if (redirect_valid) begin
            pc_d[redirect_tid]       = redirect_pc;
            pre_pend_d[redirect_tid] = 1'b0;
            pre_val_d[redirect_tid]  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= {T1_START, T0_START};
            pre_val_q     <= '0;
            pre_pend_q    <= '0;
            thread_halt_q <= '0;
            sel_q         <= 1'b0;
            out_valid     <= 1'b0;
            out_inst      <= '0;
            out_tid       <= 1'b0;
            out_pc        <= '0;
            out_pre       <= '0;
            out_pre_valid <= 1'b0;
            halted        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pre_val_q     <= pre_val_d;
            pre_pend_q    <= pre_pend_d;
            thread_halt_q <= thread_halt_d;
            sel_q         <= sel_d;
            out_valid     <= valid_d;
            out_inst      <= inst_d;
            out_tid       <= tid_d;
            out_pc        <= opc_d;
            out_pre       <= pre_d;
            out_pre_valid <= pre_valid_d;
            halted        <= halted_d;
        end
    end
endmodule

// File: tb/tb_sik_fetch.sv
// Bench for sik_fetch: directed cycle table, wrap/reset sequence, and a random run
// scored against a per-thread program walker over the instruction memory.
module tb_sik_fetch;
    logic        clk;
    logic        reset;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic        out_tid;
    logic [15:0] out_pc;
    logic [3:0]  out_pre;
    logic        out_pre_valid;
    logic        redirect_valid;
    logic        redirect_tid;
    logic [15:0] redirect_pc;
    logic [1:0]  halt_req;
    logic        halted;

    logic [15:0] mem [65536];
    int          errors = 0;
    int          checks = 0;

    assign imem_data = mem[imem_addr];

    sik_fetch #(.T0_START(16'h0000), .T1_START(16'h8000)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_tid(out_tid), .out_pc(out_pc),
        .out_pre(out_pre), .out_pre_valid(out_pre_valid),
        .redirect_valid(redirect_valid), .redirect_tid(redirect_tid),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic [1:0]  h;
        logic        ev;
        logic        et;
        logic [15:0] epc;
        logic [15:0] einst;
        logic [3:0]  epre;
        logic        epv;
        logic [15:0] ea;
        logic        ca;
        logic        eh;
    } vec_t;

    localparam int NV = 28;
    vec_t vt [NV];

    function automatic vec_t row(input logic rdy, input logic rv, input logic [15:0] rpc,
                                 input logic [1:0] h, input logic ev, input logic et,
                                 input logic [15:0] epc, input logic [15:0] einst,
                                 input logic [3:0] epre, input logic epv,
                                 input logic [15:0] ea, input logic ca, input logic eh);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.h = h; v.ev = ev; v.et = et;
        v.epc = epc; v.einst = einst; v.epre = epre; v.epv = epv;
        v.ea = ea; v.ca = ca; v.eh = eh;
        return v;
    endfunction

    function automatic logic [63:0] tup(input logic t, input logic [15:0] p,
                                        input logic [15:0] i, input logic [3:0] pr,
                                        input logic pv);
        return {26'd0, t, p, i, pr, pv};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset away from any clock edge and checks the reset state before an edge arrives.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_tid = 1'b0;
        redirect_pc = 16'h0; halt_req = 2'b00;
        #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_outs"}, tup(out_tid, out_pc, out_inst, out_pre, out_pre_valid), 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'd0);
        check({tag, "_addr"}, 64'(imem_addr), 64'h0000);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    logic [15:0] w_pc [2];
    int          ndel [2];

    initial begin
        reset = 1'b0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_tid = 1'b0;
        redirect_pc = 16'h0; halt_req = 2'b00;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1003; mem[16'h0001] = 16'h8005; mem[16'h0002] = 16'hF00A;
        mem[16'h0003] = 16'h1002; mem[16'h0004] = 16'h3004; mem[16'h0005] = 16'h4005;
        mem[16'h0006] = 16'hF007; mem[16'h0007] = 16'h5007; mem[16'h0040] = 16'h6040;
        for (int i = 0; i < 16; i++) mem[16'h8000 + i] = 16'h2001 + 16'(i);

        //           rdy   rv    rpc       halt   ev    et    epc       einst     pre   pv    addr      ca    halted
        vt[0]  = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h1003, 4'h0, 1'b0, 16'h8000, 1'b1, 1'b0);
        vt[1]  = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h8000, 16'h2001, 4'h0, 1'b0, 16'h0001, 1'b1, 1'b0);
        vt[2]  = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0001, 16'h8005, 4'h0, 1'b0, 16'h8001, 1'b1, 1'b0);
        vt[3]  = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h8001, 16'h2002, 4'h0, 1'b0, 16'h0002, 1'b1, 1'b0);
        vt[4]  = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 16'h8002, 1'b1, 1'b0);
        vt[5]  = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h8002, 16'h2003, 4'h0, 1'b0, 16'h0003, 1'b1, 1'b0);
        vt[6]  = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0003, 16'h1002, 4'hA, 1'b1, 16'h8003, 1'b1, 1'b0);
        vt[7]  = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h8003, 16'h2004, 4'h0, 1'b0, 16'h0004, 1'b1, 1'b0);
        vt[8]  = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0004, 16'h3004, 4'h0, 1'b0, 16'h8004, 1'b1, 1'b0);
        vt[9]  = row(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0004, 16'h3004, 4'h0, 1'b0, 16'h8004, 1'b1, 1'b0);
        vt[10] = row(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0004, 16'h3004, 4'h0, 1'b0, 16'h8004, 1'b1, 1'b0);
        vt[11] = row(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0004, 16'h3004, 4'h0, 1'b0, 16'h8004, 1'b1, 1'b0);
        vt[12] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h8004, 16'h2005, 4'h0, 1'b0, 16'h0005, 1'b1, 1'b0);
        vt[13] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0005, 16'h4005, 4'h0, 1'b0, 16'h8005, 1'b1, 1'b0);
        vt[14] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h8005, 16'h2006, 4'h0, 1'b0, 16'h0006, 1'b1, 1'b0);
        vt[15] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 16'h8006, 1'b1, 1'b0);
        vt[16] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h8006, 16'h2007, 4'h0, 1'b0, 16'h0007, 1'b1, 1'b0);
        vt[17] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0007, 16'h5007, 4'h7, 1'b1, 16'h8007, 1'b1, 1'b0);
        vt[18] = row(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0007, 16'h5007, 4'h7, 1'b1, 16'h8007, 1'b1, 1'b0);
        vt[19] = row(1'b0, 1'b1, 16'h0040, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 16'h8007, 1'b1, 1'b0);
        vt[20] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h8007, 16'h2008, 4'h0, 1'b0, 16'h0040, 1'b1, 1'b0);
        vt[21] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0040, 16'h6040, 4'h0, 1'b0, 16'h8008, 1'b1, 1'b0);
        vt[22] = row(1'b1, 1'b0, 16'h0000, 2'b01, 1'b1, 1'b1, 16'h8008, 16'h2009, 4'h0, 1'b0, 16'h8009, 1'b1, 1'b0);
        vt[23] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h8009, 16'h200A, 4'h0, 1'b0, 16'h800A, 1'b1, 1'b0);
        vt[24] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h800A, 16'h200B, 4'h0, 1'b0, 16'h800B, 1'b1, 1'b0);
        vt[25] = row(1'b1, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vt[26] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b1);
        vt[27] = row(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b1);

        #1;
        apply_reset("rst0");

        // Directed cycle table: interleave, prefix fold, stall, squash, halt.
        for (int i = 0; i < NV; i++) begin
            out_ready      = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_tid   = 1'b0;
            redirect_pc    = vt[i].rpc;
            halt_req       = vt[i].h;
            step();
            redirect_valid = 1'b0;
            halt_req       = 2'b00;
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vt[i].ev));
            if (vt[i].ev)
                check($sformatf("v%0d_outs", i),
                      tup(out_tid, out_pc, out_inst, out_pre, out_pre_valid),
                      tup(vt[i].et, vt[i].epc, vt[i].einst, vt[i].epre, vt[i].epv));
            if (vt[i].ca)
                check($sformatf("v%0d_addr", i), 64'(imem_addr), 64'(vt[i].ea));
            check($sformatf("v%0d_halted", i), 64'(halted), 64'(vt[i].eh));
        end

        // PC wrap on thread 1, then reset between clock edges.
        apply_reset("rst1");
        mem[16'hFFFF] = 16'h7FFF;
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_tid = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        check("wrap_a", tup(out_tid, out_pc, out_inst, out_pre, out_pre_valid),
              tup(1'b0, 16'h0000, 16'h1003, 4'h0, 1'b0));
        check("wrap_a_addr", 64'(imem_addr), 64'hFFFF);
        step();
        check("wrap_b", tup(out_tid, out_pc, out_inst, out_pre, out_pre_valid),
              tup(1'b1, 16'hFFFF, 16'h7FFF, 4'h0, 1'b0));
        step();
        check("wrap_c_addr", 64'(imem_addr), 64'h0000);
        step();
        check("wrap_d", tup(out_tid, out_pc, out_inst, out_pre, out_pre_valid),
              tup(1'b1, 16'h0000, 16'h1003, 4'h0, 1'b0));
        check("wrap_d_valid", 64'(out_valid), 64'd1);
        apply_reset("rst_mid");

        // Random run: each thread's deliveries must follow its own program walk.
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(4, 0) == 0) w[15:12] = 4'hF;
            else if (w[15:12] == 4'hF) w[15:12] = 4'h0;
            mem[i] = w;
        end
        w_pc[0] = 16'h0000; w_pc[1] = 16'h8000;
        ndel[0] = 0; ndel[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            logic        hold, sq;
            logic [63:0] snap;
            out_ready      = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(15, 0) == 0);
            redirect_tid   = 1'($urandom);
            redirect_pc    = 16'($urandom);
            if (out_valid && out_ready) begin
                logic [15:0] p, w;
                logic [3:0]  pr;
                logic        pv;
                p = w_pc[out_tid]; pr = 4'h0; pv = 1'b0; w = mem[p];
                for (int k = 0; k < 64 && w[15:12] == 4'hF; k++) begin
                    pr = w[3:0]; pv = 1'b1; p = p + 16'd1; w = mem[p];
                end
                check($sformatf("rnd%0d_t%0d", c, out_tid),
                      tup(out_tid, out_pc, out_inst, out_pre, out_pre_valid),
                      tup(out_tid, p, w, pr, pv));
                w_pc[out_tid] = p + 16'd1;
                ndel[out_tid]++;
            end
            if (redirect_valid) w_pc[redirect_tid] = redirect_pc;
            hold = out_valid && !out_ready;
            sq   = hold && redirect_valid && (redirect_tid == out_tid);
            snap = tup(out_tid, out_pc, out_inst, out_pre, out_pre_valid);
            step();
            redirect_valid = 1'b0;
            if (hold) begin
                check($sformatf("rnd%0d_hold_valid", c), 64'(out_valid), sq ? 64'd0 : 64'd1);
                if (!sq)
                    check($sformatf("rnd%0d_hold_outs", c),
                          tup(out_tid, out_pc, out_inst, out_pre, out_pre_valid), snap);
            end
        end
        check("progress_t0", 64'(ndel[0] > 300), 64'd1);
        check("progress_t1", 64'(ndel[1] > 300), 64'd1);
        check("rnd_halted", 64'(halted), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
